// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - round-robin writeback arbiter and register busy scoreboard
module rf_wb_scheduler #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [5*NREQ-1:0]    req_rd,
    input  logic [XLEN*NREQ-1:0] req_data,
    output logic                 rf_we,
    output logic [4:0]           rf_rd_addr,
    output logic [XLEN-1:0]      rf_rd_din,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    output logic                 issue_ready,
    input  logic [4:0]           chk_rs1,
    input  logic [4:0]           chk_rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [31:0]          busy_vec
);

    localparam int PW = (NREQ > 2) ? 2 : 1;

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   grant_idx;
    logic            grant_any;
    logic [4:0]      grant_rd;
    logic [XLEN-1:0] grant_data;
    logic [31:0]     busy;
    logic [31:0]     busy_next;
    int              idx;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_rd   = '0;
        grant_data = '0;
        idx        = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any  = 1'b1;
                grant_idx  = idx[PW-1:0];
                grant_rd   = req_rd[5*idx +: 5];
                grant_data = req_data[XLEN*idx +: XLEN];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_any && rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign issue_ready = rst && ((issue_rd == 5'd0) || !busy[issue_rd]);
    assign rs1_busy    = busy[chk_rs1];
    assign rs2_busy    = busy[chk_rs2];
    assign busy_vec    = busy;

    // Clear on writeback first so a same-cycle issue to that register wins.
    always_comb begin
        busy_next = busy;
        if (grant_any && grant_rd != 5'd0) begin
            busy_next[grant_rd] = 1'b0;
        end
        if (issue_valid && issue_ready && issue_rd != 5'd0) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr     <= '0;
            busy       <= '0;
            rf_we      <= 1'b0;
            rf_rd_addr <= '0;
            rf_rd_din  <= '0;
        end else begin
            busy  <= busy_next;
            rf_we <= grant_any && (grant_rd != 5'd0);
            if (grant_any) begin
                rr_ptr     <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                rf_rd_addr <= grant_rd;
                rf_rd_din  <= grant_data;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb/tb_rf_wb_scheduler.sv - directed scoreboard bench for rf_wb_scheduler
module tb_rf_wb_scheduler;

    localparam int N  = 3;
    localparam int XL = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [5*N-1:0]  req_rd;
    logic [XL*N-1:0] req_data;
    logic          rf_we;
    logic [4:0]    rf_rd_addr;
    logic [XL-1:0] rf_rd_din;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic          issue_ready;
    logic [4:0]    chk_rs1, chk_rs2;
    logic          rs1_busy, rs2_busy;
    logic [31:0]   busy_vec;

    int total = 0;
    int bad   = 0;

    int          m_ptr;
    logic [31:0] m_busy;
    logic [4:0]  m_addr;
    logic [31:0] m_din;
    logic [37:0] wq[$];
    logic [31:0] rf_mem[32];

    rf_wb_scheduler #(.NREQ(N), .XLEN(XL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd), .req_data(req_data),
        .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_din(rf_rd_din),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_rd_addr] <= rf_rd_din;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
        req_valid[i]        = v;
        req_rd[5*i +: 5]    = rd;
        req_data[XL*i +: XL] = d;
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_busy = '0;
        m_addr = '0;
        m_din  = '0;
        wq.delete();
    endtask

    // One clock: check comb outputs and the scoreboard at negedge, advance the model, step past posedge.
    task automatic cycle();
        int          g;
        logic [N-1:0] exp_ready;
        logic        exp_iready;
        logic [37:0] e;
        logic [4:0]  rd;
        @(negedge clk);
        g = -1;
        exp_ready = '0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (g < 0 && req_valid[j]) g = j;
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        exp_iready = (issue_rd == 5'd0) || !m_busy[issue_rd];
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("issue_ready", 32'(issue_ready), 32'(exp_iready));
        check("busy_vec", busy_vec, m_busy);
        check("rs1_busy", 32'(rs1_busy), 32'(m_busy[chk_rs1]));
        check("rs2_busy", 32'(rs2_busy), 32'(m_busy[chk_rs2]));
        if (wq.size() != 0) begin
            e = wq.pop_front();
            m_addr = e[36:32];
            m_din  = e[31:0];
            check("rf_we", 32'(rf_we), 32'(e[37]));
        end else begin
            check("rf_we_idle", 32'(rf_we), 32'd0);
        end
        check("rf_rd_addr", 32'(rf_rd_addr), 32'(m_addr));
        check("rf_rd_din", rf_rd_din, m_din);
        if (g >= 0) begin
            rd = req_rd[5*g +: 5];
            wq.push_back({rd != 5'd0, rd, req_data[XL*g +: XL]});
            if (rd != 5'd0) m_busy[rd] = 1'b0;
            m_ptr = (g + 1) % N;
        end
        if (issue_valid && exp_iready && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = '0; req_rd = '0; req_data = '0;
        issue_valid = 1'b0; issue_rd = '0; chk_rs1 = '0; chk_rs2 = '0;
        for (int i = 0; i < 32; i++) rf_mem[i] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_busy", busy_vec, 32'd0);
        check("rst_iready", 32'(issue_ready), 32'd0);
        rst = 1'b1;

        // Round-robin with all requesters valid
        set_req(0, 1'b1, 5'd5, 32'hA);
        set_req(1, 1'b1, 5'd6, 32'hB);
        set_req(2, 1'b1, 5'd7, 32'hC);
        repeat (6) cycle();
        req_valid = '0;
        cycle();

        // Writeback to x0
        set_req(1, 1'b1, 5'd0, 32'hDEADBEEF);
        cycle();
        req_valid = '0;
        cycle();
        check("x0_busy", busy_vec, 32'd0);

        // RAW on x9
        chk_rs1 = 5'd9; chk_rs2 = 5'd7;
        issue_valid = 1'b1; issue_rd = 5'd9;
        cycle();
        issue_valid = 1'b0;
        #1;
        check("raw_busy9", 32'(busy_vec[9]), 32'd1);
        check("raw_rs1", 32'(rs1_busy), 32'd1);
        cycle();

        // WAW stall until the writeback grant edge
        issue_valid = 1'b1; issue_rd = 5'd9;
        #1;
        check("waw_stall", 32'(issue_ready), 32'd0);
        cycle();
        set_req(1, 1'b1, 5'd9, 32'h1234);
        cycle();
        req_valid = '0;
        #1;
        check("waw_release", 32'(issue_ready), 32'd1);
        check("raw_cleared", 32'(rs1_busy), 32'd0);
        cycle();
        issue_valid = 1'b0;
        cycle();
        check("rf_x9", rf_mem[9], 32'h1234);

        // x0 issue is never stalled
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        check("x0_issue", 32'(issue_ready), 32'd1);
        cycle();

        // Same-cycle issue and writeback to x4: set wins
        issue_rd = 5'd4;
        set_req(0, 1'b1, 5'd4, 32'h44);
        cycle();
        req_valid = '0; issue_valid = 1'b0;
        #1;
        check("sim_busy4", 32'(busy_vec[4]), 32'd1);
        cycle();
        check("rf_x4", rf_mem[4], 32'h44);

        // Reset in the middle of traffic
        set_req(0, 1'b1, 5'd10, 32'h10);
        set_req(1, 1'b1, 5'd11, 32'h11);
        set_req(2, 1'b1, 5'd12, 32'h12);
        issue_valid = 1'b1; issue_rd = 5'd13;
        cycle();
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_we", 32'(rf_we), 32'd0);
        check("mid_rst_addr", 32'(rf_rd_addr), 32'd0);
        check("mid_rst_din", rf_rd_din, 32'd0);
        check("mid_rst_busy", busy_vec, 32'd0);
        check("mid_rst_iready", 32'(issue_ready), 32'd0);
        model_reset();
        issue_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 3'b100;
        #1;
        check("post_rst_grant2", 32'(req_ready), 32'h4);
        cycle();
        req_valid = '0;
        repeat (2) cycle();
        check("rf_x12", rf_mem[12], 32'h12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
